fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Single-clock write-port arbiter: shares one asynchronous FIFO write port among NREQ requesters.
- Sits in the FIFO write-clock domain: fifo_wr_en/fifo_din drive the FIFO wr_en/din, fifo_full comes from the FIFO full flag.
- Rotating (round-robin) priority; each grant is a burst of at most MAX_BURST words; writes are never issued while full.

Parameters:
- NREQ, 4, number of requesters (2..16).
- DW, 8, data width; must equal the FIFO write width.
- MAX_BURST, 8, maximum words written per grant (1..256).

Ports:
- clk  input  1  write-domain clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  NREQ  per-requester write request, held while it has data.
- din  input  NREQ*DW  requester data, slice i = din[i*DW +: DW].
- gnt  output  NREQ  one-hot grant (registered).
- ack  output  NREQ  word accepted this cycle for requester i (combinational).
- fifo_full  input  1  FIFO full flag.
- fifo_wr_en  output  1  FIFO write enable (combinational).
- fifo_din  output  DW  FIFO write data (combinational mux of owner slice).
- busy  output  1  high while in BURST.
- owner  output  clog2(NREQ)  index of granted requester; valid when busy.

Behaviour:
- Reset (async, immediate): state=IDLE, gnt=0, busy=0, owner=0, rr_ptr=0, beat_cnt=0; ack=0, fifo_wr_en=0 and fifo_din=0 follow from IDLE.
- State IDLE:
  - If req != 0, select the first set req[i] scanning rr_ptr, rr_ptr+1, ... mod NREQ.
  - Next edge: owner=i, gnt=onehot(i), busy=1, beat_cnt=0, state=BURST.
  - No writes in IDLE.
- State BURST, per cycle:
  - write = req[owner] & ~fifo_full.
  - fifo_wr_en = write; ack[owner] = write; fifo_din = din slice owner when busy, else 0.
  - On a write: beat_cnt increments.
- Release from BURST, either condition:
  - A write occurs with beat_cnt == MAX_BURST-1: the last word is written, then release.
  - req[owner] == 0: no write that cycle, release.
- On release (next edge): state=IDLE, gnt=0, busy=0, rr_ptr=(owner+1) mod NREQ.
- Grant timing:
  - One IDLE bubble cycle between consecutive grants.
  - First write can occur one cycle after the request is seen in IDLE.
- fifo_full in BURST:
  - Grant is held indefinitely; no writes, no beat count.
  - Writing resumes the first cycle full is low.
- fifo_full and req[owner] low in the same cycle: release (req drop wins).
- Non-owner req changes during BURST are ignored until IDLE.
- Requester protocol:
  - Presents the next word on its slice in the cycle after each ack.
  - May drop req at any time; a dropped request loses its grant.
- Throughput: up to MAX_BURST words per grant, 1 word/cycle when not full.
- Reset mid-burst: outputs cleared immediately; partially written burst is not tracked.
- MAX_BURST=1: exactly one word per grant.
- rr_ptr wraps NREQ-1 -> 0.

Test Plan:
- Single requester: req[2]=1 continuously, NREQ=4, MAX_BURST=8, full=0 -> gnt=0100 one cycle after req; 8 consecutive fifo_wr_en with din[2] words; 1 bubble; regrant to 2; rr_ptr=3 after first release.
- All four req high from reset -> grant order 0,1,2,3,0; each grant writes exactly 8 words; gnt always one-hot or zero.
- Full stall: owner 1 mid-burst after 3 words, fifo_full=1 for 5 cycles -> fifo_wr_en=0 and ack=0 during stall, gnt held; remaining 5 words written after full drops; total 8.
- Early drop: owner 0 drops req after 2 acks -> no write that cycle, gnt=0 next cycle, next grant goes to requester 1 if requesting.
- Async reset asserted mid-burst (beat 4) -> gnt, busy, fifo_wr_en go 0 without a clock edge; after release, first grant starts from requester 0.
- MAX_BURST=1, req=1010 -> alternating single-word grants to 1,3,1,3 with one idle cycle between each.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter sharing one FIFO write port
module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int DW        = 8,
    parameter int MAX_BURST = 8,
    localparam int IW       = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int CW       = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ*DW-1:0] din,
    output logic [NREQ-1:0]  gnt,
    output logic [NREQ-1:0]  ack,
    input  logic             fifo_full,
    output logic             fifo_wr_en,
    output logic [DW-1:0]    fifo_din,
    output logic             busy,
    output logic [IW-1:0]    owner
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t          r_state;
    logic [NREQ-1:0] r_gnt;
    logic            r_busy;
    logic [IW-1:0]   r_owner;
    logic [IW-1:0]   r_rr_ptr;
    logic [CW-1:0]   r_beat_cnt;

    logic            w_found;
    logic [IW-1:0]   w_sel;
    logic            w_owner_req;
    logic            w_write;
    logic            w_last_beat;
    logic [NREQ-1:0] w_ack;
    logic [IW-1:0]   w_next_ptr;

    // Rotating scan: the first requester at or after the pointer wins.
    always_comb begin
        int idx;
        w_found = 1'b0;
        w_sel   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(r_rr_ptr) + k) % NREQ;
            if (!w_found && req[idx]) begin
                w_found = 1'b1;
                w_sel   = IW'(idx);
            end
        end
    end

    assign w_owner_req = req[r_owner];
    assign w_write     = r_busy & w_owner_req & ~fifo_full;
    assign w_last_beat = (r_beat_cnt == CW'(MAX_BURST - 1));
    assign w_next_ptr  = (r_owner == IW'(NREQ - 1)) ? '0 : r_owner + 1'b1;

    always_comb begin
        w_ack = '0;
        if (w_write) begin
            w_ack[r_owner] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_gnt      <= '0;
            r_busy     <= 1'b0;
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_state    <= BURST;
                        r_owner    <= w_sel;
                        r_gnt      <= NREQ'(1) << w_sel;
                        r_busy     <= 1'b1;
                        r_beat_cnt <= '0;
                    end
                end
                BURST: begin
                    // A dropped request releases even while the FIFO is full.
                    if (!w_owner_req || (w_write && w_last_beat)) begin
                        r_state  <= IDLE;
                        r_gnt    <= '0;
                        r_busy   <= 1'b0;
                        r_rr_ptr <= w_next_ptr;
                    end else if (w_write) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt        = r_gnt;
    assign busy       = r_busy;
    assign owner      = r_owner;
    assign ack        = w_ack;
    assign fifo_wr_en = w_write;
    assign fifo_din   = r_busy ? din[r_owner*DW +: DW] : '0;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [3:0]  req = '0;
    logic [31:0] din = '0;
    logic        full = 1'b0;
    logic [3:0]  gnt, ack;
    logic        wr_en, busy;
    logic [7:0]  fdin;
    logic [1:0]  owner;

    logic [3:0]  req2 = '0;
    logic [31:0] din2 = 32'hD4C3B2A1;
    logic        full2 = 1'b0;
    logic [3:0]  gnt2, ack2;
    logic        wr_en2, busy2;
    logic [7:0]  fdin2;
    logic [1:0]  owner2;

    int n_chk = 0;
    int n_err = 0;

    fifo_wr_arbiter #(.NREQ(4), .DW(8), .MAX_BURST(8)) u_dut (
        .clk(clk), .rst(rst), .req(req), .din(din), .gnt(gnt), .ack(ack),
        .fifo_full(full), .fifo_wr_en(wr_en), .fifo_din(fdin),
        .busy(busy), .owner(owner)
    );

    fifo_wr_arbiter #(.NREQ(4), .DW(8), .MAX_BURST(1)) u_dut1 (
        .clk(clk), .rst(rst), .req(req2), .din(din2), .gnt(gnt2), .ack(ack2),
        .fifo_full(full2), .fifo_wr_en(wr_en2), .fifo_din(fdin2),
        .busy(busy2), .owner(owner2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic       full;
        logic [3:0] gnt;
        logic [3:0] ack;
        logic       wr;
        logic       busy;
        logic [1:0] owner;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        full = 1'b0;
        req2 = '0;
        full2 = 1'b0;
        next_cyc();
        next_cyc();
        rst = 1'b0;
    endtask

    function automatic vec_t mk(input logic [3:0] r, input logic f, input logic [3:0] g,
                                input logic [3:0] a, input logic w, input logic b,
                                input logic [1:0] o);
        vec_t v;
        v.req = r; v.full = f; v.gnt = g; v.ack = a; v.wr = w; v.busy = b; v.owner = o;
        return v;
    endfunction

    // Reference model: owner of -1 means no grant outstanding.
    int m_owner;
    int m_words;
    int m_start;

    task automatic model_cycle();
        logic [3:0] e_gnt, e_ack;
        logic       e_wr, e_busy, writing;
        logic [7:0] e_din;
        int         pick;
        e_gnt = '0; e_ack = '0; e_wr = 1'b0; e_busy = 1'b0; e_din = '0;
        writing = 1'b0;
        if (m_owner >= 0) begin
            e_busy  = 1'b1;
            e_gnt   = 4'(1 << m_owner);
            writing = req[m_owner] && !full;
            e_wr    = writing;
            e_ack   = writing ? e_gnt : 4'b0;
            e_din   = din[m_owner*8 +: 8];
        end
        chk("rand_gnt", 32'(gnt), 32'(e_gnt));
        chk("rand_ack", 32'(ack), 32'(e_ack));
        chk("rand_wr_en", 32'(wr_en), 32'(e_wr));
        chk("rand_busy", 32'(busy), 32'(e_busy));
        chk("rand_fifo_din", 32'(fdin), 32'(e_din));
        if (m_owner >= 0) chk("rand_owner", 32'(owner), 32'(m_owner));
        if (m_owner < 0) begin
            pick = -1;
            for (int k = 0; k < 4; k++) begin
                if (pick < 0 && req[(m_start + k) % 4]) pick = (m_start + k) % 4;
            end
            if (pick >= 0) begin
                m_owner = pick;
                m_words = 0;
            end
        end else if (!req[m_owner] || (writing && m_words + 1 == 8)) begin
            m_start = (m_owner + 1) % 4;
            m_owner = -1;
        end else if (writing) begin
            m_words++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] dsave;
        int wcount;

        #1;
        chk("reset_gnt", 32'(gnt), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_wr_en", 32'(wr_en), 0);
        chk("reset_owner", 32'(owner), 0);
        chk("reset_fifo_din", 32'(fdin), 0);

        // Table: single requester bursts, stall, drop, pointer rotation.
        tbl.push_back(mk(4'b0100, 0, 4'b0000, 4'b0000, 0, 0, 0));
        for (int i = 0; i < 8; i++) tbl.push_back(mk(4'b0100, 0, 4'b0100, 4'b0100, 1, 1, 2));
        tbl.push_back(mk(4'b0100, 0, 4'b0000, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(4'b0100, 0, 4'b0100, 4'b0100, 1, 1, 2));
        tbl.push_back(mk(4'b0100, 1, 4'b0100, 4'b0000, 0, 1, 2));
        tbl.push_back(mk(4'b0100, 0, 4'b0100, 4'b0100, 1, 1, 2));
        tbl.push_back(mk(4'b0000, 0, 4'b0100, 4'b0000, 0, 1, 2));
        tbl.push_back(mk(4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(4'b1010, 1, 4'b0000, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(4'b1010, 1, 4'b1000, 4'b0000, 0, 1, 3));
        tbl.push_back(mk(4'b0010, 0, 4'b1000, 4'b0000, 0, 1, 3));
        tbl.push_back(mk(4'b1010, 0, 4'b0000, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(4'b1010, 0, 4'b0010, 4'b0010, 1, 1, 1));

        do_reset();
        din = 32'h44332211;
        dsave = din;
        foreach (tbl[i]) begin
            req  = tbl[i].req;
            full = tbl[i].full;
            @(negedge clk);
            chk($sformatf("tbl%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
            chk($sformatf("tbl%0d_ack", i), 32'(ack), 32'(tbl[i].ack));
            chk($sformatf("tbl%0d_wr_en", i), 32'(wr_en), 32'(tbl[i].wr));
            chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
            chk($sformatf("tbl%0d_fifo_din", i), 32'(fdin),
                tbl[i].busy ? 32'(dsave[tbl[i].owner*8 +: 8]) : 32'd0);
            if (tbl[i].busy) chk($sformatf("tbl%0d_owner", i), 32'(owner), 32'(tbl[i].owner));
            next_cyc();
        end

        // All four requesting: order 0,1,2,3,0 with 8 words and one bubble each.
        do_reset();
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            @(negedge clk);
            chk("all4_bubble_busy", 32'(busy), 0);
            next_cyc();
            wcount = 0;
            for (int n = 0; n < 8; n++) begin
                @(negedge clk);
                chk("all4_gnt", 32'(gnt), 32'(1 << (g % 4)));
                if (wr_en) wcount++;
                next_cyc();
            end
            chk("all4_words", wcount, 8);
        end

        // Full stall after 3 words of owner 1.
        do_reset();
        req = 4'b0010;
        @(negedge clk);
        chk("stall_idle_busy", 32'(busy), 0);
        next_cyc();
        wcount = 0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            if (wr_en) wcount++;
            next_cyc();
        end
        full = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk("stall_wr_en", 32'(wr_en), 0);
            chk("stall_ack", 32'(ack), 0);
            chk("stall_gnt", 32'(gnt), 32'b0010);
            next_cyc();
        end
        full = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (wr_en) wcount++;
            next_cyc();
        end
        chk("stall_total_words", wcount, 8);
        @(negedge clk);
        chk("stall_release_busy", 32'(busy), 0);
        next_cyc();

        // Early drop by owner 0 after two acks.
        do_reset();
        req = 4'b0011;
        @(negedge clk);
        next_cyc();
        wcount = 0;
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            chk("drop_owner", 32'(owner), 0);
            if (ack[0]) wcount++;
            next_cyc();
        end
        chk("drop_acks", wcount, 2);
        req = 4'b0010;
        @(negedge clk);
        chk("drop_cycle_wr_en", 32'(wr_en), 0);
        chk("drop_cycle_busy", 32'(busy), 1);
        next_cyc();
        @(negedge clk);
        chk("drop_after_gnt", 32'(gnt), 0);
        next_cyc();
        @(negedge clk);
        chk("drop_next_gnt", 32'(gnt), 32'b0010);
        chk("drop_next_wr_en", 32'(wr_en), 1);
        next_cyc();

        // Async reset at beat 4 of a burst owned by requester 1.
        do_reset();
        req = 4'b0001;
        next_cyc();
        req = 4'b0000;
        next_cyc();
        req = 4'b1111;
        for (int n = 0; n < 5; n++) next_cyc();
        chk("areset_pre_owner", 32'(owner), 1);
        chk("areset_pre_wr_en", 32'(wr_en), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("areset_gnt", 32'(gnt), 0);
        chk("areset_busy", 32'(busy), 0);
        chk("areset_wr_en", 32'(wr_en), 0);
        chk("areset_fifo_din", 32'(fdin), 0);
        next_cyc();
        rst = 1'b0;
        next_cyc();
        @(negedge clk);
        chk("areset_first_owner", 32'(owner), 0);
        chk("areset_first_gnt", 32'(gnt), 32'b0001);
        next_cyc();
        req = '0;

        // MAX_BURST=1 alternation between requesters 1 and 3.
        do_reset();
        req2 = 4'b1010;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k % 2 == 0) begin
                chk("mb1_idle_wr_en", 32'(wr_en2), 0);
                chk("mb1_idle_busy", 32'(busy2), 0);
            end else begin
                chk("mb1_wr_en", 32'(wr_en2), 1);
                chk("mb1_owner", 32'(owner2), (k % 4 == 1) ? 1 : 3);
                chk("mb1_ack", 32'(ack2), (k % 4 == 1) ? 32'b0010 : 32'b1000);
                chk("mb1_fifo_din", 32'(fdin2), (k % 4 == 1) ? 32'hB2 : 32'hD4);
            end
            next_cyc();
        end
        req2 = '0;

        // Randomized traffic against the reference model.
        do_reset();
        m_owner = -1;
        m_words = 0;
        m_start = 0;
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (req[i]) begin
                    if ($urandom_range(0, 15) == 0) req[i] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                end
            end
            full = ($urandom_range(0, 4) == 0);
            din  = $urandom;
            @(negedge clk);
            model_cycle();
            next_cyc();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
